// File: rtl/dac_osc_ctrl_seq.sv
// Control stage for the DAC / ring-oscillator test macro: generates the
// 3-bit DAC code pattern at a programmable step rate and drives the pad
// output selects with a break-before-make guard interval.
module dac_osc_ctrl_seq #(
    parameter int unsigned DIV_W        = 8,
    parameter int unsigned GUARD_CYCLES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ena,
    input  logic [1:0]       cfg_mode,
    input  logic [2:0]       cfg_code,
    input  logic [DIV_W-1:0] cfg_div,
    input  logic [1:0]       sel_req,
    input  logic             osc_en_req,
    output logic [2:0]       dac_code,
    output logic             out_dac,
    output logic             out_ro,
    output logic             out_short,
    output logic             enable,
    output logic             step_pulse,
    output logic             busy
);

    localparam int unsigned GW = (GUARD_CYCLES > 1) ? $clog2(GUARD_CYCLES) : 1;
    localparam logic [GW-1:0] GUARD_LAST = GW'(GUARD_CYCLES - 1);

    localparam logic [1:0] MODE_STATIC = 2'b00;
    localparam logic [1:0] MODE_UP     = 2'b01;
    localparam logic [1:0] MODE_TRI    = 2'b10;
    localparam logic [1:0] MODE_DOWN   = 2'b11;

    localparam logic [1:0] SEL_DAC   = 2'b01;
    localparam logic [1:0] SEL_RO    = 2'b10;
    localparam logic [1:0] SEL_SHORT = 2'b11;

    typedef enum logic {
        S_HOLD  = 1'b0,
        S_BREAK = 1'b1
    } sel_state_t;

    // ------------------------------------------------------------------
    // Code generator
    // ------------------------------------------------------------------
    logic [DIV_W-1:0] cnt;
    logic [1:0]       mode_q;
    logic             dir_up;
    logic             mode_chg;
    logic             tick;
    logic             up_eff;
    logic [2:0]       code_nxt;

    assign mode_chg = (cfg_mode != mode_q);
    assign tick     = (cnt >= cfg_div);
    // Triangle reverses at an endpoint so each endpoint appears for one step only
    assign up_eff   = dir_up ? (dac_code != 3'd7) : (dac_code == 3'd0);

    // Next code value for a step in the current pattern
    always_comb begin
        code_nxt = dac_code;
        case (mode_q)
            MODE_UP:   code_nxt = dac_code + 3'd1;
            MODE_DOWN: code_nxt = dac_code - 3'd1;
            MODE_TRI:  code_nxt = up_eff ? (dac_code + 3'd1) : (dac_code - 3'd1);
            default:   code_nxt = dac_code;
        endcase
    end

    // Prescaler, code register and triangle direction
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt        <= '0;
            mode_q     <= MODE_STATIC;
            dir_up     <= 1'b1;
            dac_code   <= 3'd0;
            step_pulse <= 1'b0;
        end else if (mode_chg) begin
            cnt        <= '0;
            mode_q     <= cfg_mode;
            dir_up     <= 1'b1;
            dac_code   <= cfg_code;
            step_pulse <= 1'b0;
        end else if (ena) begin
            cnt        <= tick ? '0 : (cnt + DIV_W'(1));
            step_pulse <= tick;
            if (mode_q == MODE_STATIC) begin
                dac_code <= cfg_code;
            end else if (tick) begin
                dac_code <= code_nxt;
                if (mode_q == MODE_TRI) begin
                    dir_up <= up_eff;
                end
            end
        end else begin
            step_pulse <= 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Output-select FSM
    // ------------------------------------------------------------------
    sel_state_t state, state_nxt;
    logic [1:0]    applied, applied_nxt;
    logic [1:0]    target, target_nxt;
    logic [GW-1:0] gcnt, gcnt_nxt;

    logic dac_d;
    logic ro_d;
    logic short_d;
    logic busy_d;
    logic enable_d;

    // State register with applied select, pending target and guard counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_HOLD;
            applied <= 2'b00;
            target  <= 2'b00;
            gcnt    <= '0;
        end else begin
            state   <= state_nxt;
            applied <= applied_nxt;
            target  <= target_nxt;
            gcnt    <= gcnt_nxt;
        end
    end

    // Next-state: enter guard on a new request, restart on any change during guard
    always_comb begin
        state_nxt   = state;
        applied_nxt = applied;
        target_nxt  = target;
        gcnt_nxt    = gcnt;
        case (state)
            S_HOLD: begin
                if (sel_req != applied) begin
                    state_nxt  = S_BREAK;
                    target_nxt = sel_req;
                    gcnt_nxt   = '0;
                end
            end
            S_BREAK: begin
                if (sel_req != target) begin
                    target_nxt = sel_req;
                    gcnt_nxt   = '0;
                end else if (gcnt == GUARD_LAST) begin
                    state_nxt   = S_HOLD;
                    applied_nxt = target;
                    gcnt_nxt    = '0;
                end else begin
                    gcnt_nxt = gcnt + GW'(1);
                end
            end
            default: begin
                state_nxt = S_HOLD;
            end
        endcase
    end

    // Output decode from the upcoming state so the pins change with the state
    always_comb begin
        dac_d    = 1'b0;
        ro_d     = 1'b0;
        short_d  = 1'b0;
        busy_d   = (state_nxt == S_BREAK);
        enable_d = osc_en_req && (applied_nxt != SEL_SHORT);
        if (state_nxt == S_HOLD) begin
            dac_d   = (applied_nxt == SEL_DAC);
            ro_d    = (applied_nxt == SEL_RO);
            short_d = (applied_nxt == SEL_SHORT);
        end
    end

    // Registered macro control outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_dac   <= 1'b0;
            out_ro    <= 1'b0;
            out_short <= 1'b0;
            busy      <= 1'b0;
            enable    <= 1'b0;
        end else begin
            out_dac   <= dac_d;
            out_ro    <= ro_d;
            out_short <= short_d;
            busy      <= busy_d;
            enable    <= enable_d;
        end
    end

endmodule

// File: tb/tb_dac_osc_ctrl_seq.sv
// Self-checking bench for dac_osc_ctrl_seq: directed scenarios followed by
// randomized traffic, all compared against a behavioural reference model.
module tb_dac_osc_ctrl_seq;

    localparam int G = 4;

    logic       clk;
    logic       rst_n;
    logic       ena;
    logic [1:0] cfg_mode;
    logic [2:0] cfg_code;
    logic [7:0] cfg_div;
    logic [1:0] sel_req;
    logic       osc_en_req;
    logic [2:0] dac_code;
    logic       out_dac;
    logic       out_ro;
    logic       out_short;
    logic       enable;
    logic       step_pulse;
    logic       busy;

    int n_checks = 0;
    int n_err    = 0;

    // Reference model state
    int m_cnt, m_mode, m_code, m_tpos, m_step;
    int m_app, m_tgt, m_rem, m_en;

    dac_osc_ctrl_seq #(.DIV_W(8), .GUARD_CYCLES(G)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ena        (ena),
        .cfg_mode   (cfg_mode),
        .cfg_code   (cfg_code),
        .cfg_div    (cfg_div),
        .sel_req    (sel_req),
        .osc_en_req (osc_en_req),
        .dac_code   (dac_code),
        .out_dac    (out_dac),
        .out_ro     (out_ro),
        .out_short  (out_short),
        .enable     (enable),
        .step_pulse (step_pulse),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Triangle waveform as a 14-entry periodic sequence 0..7..1
    function automatic int tri_val(input int p);
        return (p <= 7) ? p : 14 - p;
    endfunction

    task automatic model_reset();
        m_cnt = 0; m_mode = 0; m_code = 0; m_tpos = 0; m_step = 0;
        m_app = 0; m_tgt = 0; m_rem = 0; m_en = 0;
    endtask

    task automatic model_update();
        int mode, sel;
        mode = int'(cfg_mode);
        sel  = int'(sel_req);
        if (mode != m_mode) begin
            m_mode = mode;
            m_code = int'(cfg_code);
            m_tpos = int'(cfg_code);
            m_cnt  = 0;
            m_step = 0;
        end else if (ena) begin
            m_step = (m_cnt >= int'(cfg_div)) ? 1 : 0;
            m_cnt  = (m_step != 0) ? 0 : m_cnt + 1;
            if (mode == 0) begin
                m_code = int'(cfg_code);
            end else if (m_step != 0) begin
                if (mode == 1) m_code = (m_code + 1) % 8;
                else if (mode == 3) m_code = (m_code + 7) % 8;
                else begin
                    m_tpos = (m_tpos + 1) % 14;
                    m_code = tri_val(m_tpos);
                end
            end
        end else begin
            m_step = 0;
        end
        // Select path: m_rem counts guard cycles still to go
        if (m_rem == 0) begin
            if (sel != m_app) begin
                m_tgt = sel;
                m_rem = G;
            end
        end else if (sel != m_tgt) begin
            m_tgt = sel;
            m_rem = G;
        end else begin
            m_rem = m_rem - 1;
            if (m_rem == 0) m_app = m_tgt;
        end
        m_en = (osc_en_req && m_app != 3) ? 1 : 0;
    endtask

    task automatic check_all();
        chk("dac_code",   32'(dac_code),   32'(m_code));
        chk("step_pulse", 32'(step_pulse), 32'(m_step));
        chk("out_dac",    32'(out_dac),    32'((m_rem == 0 && m_app == 1) ? 1 : 0));
        chk("out_ro",     32'(out_ro),     32'((m_rem == 0 && m_app == 2) ? 1 : 0));
        chk("out_short",  32'(out_short),  32'((m_rem == 0 && m_app == 3) ? 1 : 0));
        chk("busy",       32'(busy),       32'((m_rem != 0) ? 1 : 0));
        chk("enable",     32'(enable),     32'(m_en));
        chk("onehot_sel", 32'(($countones({out_dac, out_ro, out_short}) <= 1) ? 1 : 0), 32'd1);
    endtask

    task automatic step();
        @(posedge clk);
        if (!rst_n) model_reset();
        else model_update();
        @(negedge clk);
        check_all();
    endtask

    initial begin
        int pulses, first, busy_n;
        int ramp_exp[3];
        int dn_exp[3];
        int tri_exp[11];
        ramp_exp = '{7, 0, 1};
        dn_exp   = '{1, 0, 7};
        tri_exp  = '{5, 6, 7, 6, 5, 4, 3, 2, 1, 0, 1};

        rst_n = 1'b0; ena = 1'b0; cfg_mode = 2'b00; cfg_code = 3'd0;
        cfg_div = 8'd0; sel_req = 2'b00; osc_en_req = 1'b0;
        model_reset();
        repeat (2) step();
        rst_n = 1'b1;

        // Build a live state, then pull reset asynchronously mid-cycle
        ena = 1'b1; cfg_code = 3'd5; sel_req = 2'b10;
        repeat (7) step();
        chk("pre_rst_code", 32'(dac_code), 32'd5);
        chk("pre_rst_ro",   32'(out_ro),   32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_code", 32'(dac_code), 32'd0);
        chk("async_rst_ro",   32'(out_ro),   32'd0);
        chk("async_rst_outs", 32'({out_dac, out_short, enable, step_pulse, busy}), 32'd0);
        model_reset();
        cfg_code = 3'd0; sel_req = 2'b00;
        repeat (2) step();
        rst_n = 1'b1;
        step();
        chk("rel_code", 32'(dac_code), 32'd0);
        chk("rel_busy", 32'(busy),     32'd0);

        // Ramp-up every 3 cycles from 6
        cfg_mode = 2'b01; cfg_code = 3'd6; cfg_div = 8'd2;
        step();
        chk("ramp_start", 32'(dac_code), 32'd6);
        pulses = 0;
        for (int k = 0; k < 3; k++) begin
            repeat (3) begin
                step();
                pulses += int'(step_pulse);
            end
            chk("ramp_code", 32'(dac_code), 32'(ramp_exp[k]));
        end
        chk("ramp_pulses", 32'(pulses), 32'd3);

        // Triangle from 5 with an ena pause
        cfg_mode = 2'b10; cfg_code = 3'd5; cfg_div = 8'd0;
        step();
        chk("tri_start", 32'(dac_code), 32'(tri_exp[0]));
        for (int i = 1; i < 11; i++) begin
            if (i == 5) begin
                ena = 1'b0;
                repeat (4) begin
                    step();
                    chk("tri_hold",    32'(dac_code),   32'(tri_exp[4]));
                    chk("tri_nopulse", 32'(step_pulse), 32'd0);
                end
                ena = 1'b1;
            end
            step();
            chk("tri_code", 32'(dac_code), 32'(tri_exp[i]));
        end

        // Break-before-make DAC -> RO
        sel_req = 2'b01;
        repeat (6) step();
        chk("bbm_dac_on", 32'(out_dac), 32'd1);
        sel_req = 2'b10;
        step();
        chk("bbm_dac_off", 32'(out_dac), 32'd0);
        busy_n = int'(busy);
        first = 0;
        for (int i = 2; i <= 10; i++) begin
            step();
            busy_n += int'(busy);
            if (out_ro && first == 0) first = i;
        end
        chk("bbm_busy_len", 32'(busy_n), 32'(G));
        chk("bbm_ro_lat",   32'(first),  32'(G + 1));

        // Guard restart RO -> DAC -> short, oscillator requested on
        osc_en_req = 1'b1;
        sel_req = 2'b01;
        step();
        step();
        sel_req = 2'b11;
        first = 0;
        for (int i = 1; i <= 10; i++) begin
            step();
            if (out_short && first == 0) first = i;
        end
        chk("restart_short_lat", 32'(first),     32'(G + 1));
        chk("short_on",          32'(out_short), 32'd1);
        chk("short_enable_off",  32'(enable),    32'd0);
        sel_req = 2'b00;
        repeat (6) step();

        // Divisor shrink below the running count, then ramp-down
        cfg_mode = 2'b01; cfg_div = 8'd200;
        step();
        repeat (50) step();
        cfg_div = 8'd1;
        step();
        chk("div_shrink_tick", 32'(step_pulse), 32'd1);
        cfg_mode = 2'b11; cfg_code = 3'd2;
        step();
        chk("down_start", 32'(dac_code), 32'd2);
        for (int k = 0; k < 3; k++) begin
            repeat (2) step();
            chk("down_code", 32'(dac_code), 32'(dn_exp[k]));
        end

        // Randomized traffic
        for (int n = 0; n < 800; n++) begin
            rst_n    = ($urandom_range(0, 199) != 0);
            ena      = ($urandom_range(0, 7) != 0);
            cfg_code = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 15) == 0) cfg_mode = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 31) == 0) cfg_div  = 8'($urandom_range(0, 3));
            if ($urandom_range(0, 5) == 0)  sel_req  = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 3) == 0)  osc_en_req = 1'($urandom_range(0, 1));
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
